// File: rtl/button_event_capture.sv
`timescale 1ns/1ps
// button_event_capture
//   Debounces four raw active-low push-buttons and turns their debounced
//   transitions into strobes, sticky host-visible flags, a running press
//   count and a sticky overflow indication.
//
// Parameters
//   DB_CYCLES : consecutive stable synchronized cycles needed to accept a
//               level change (2..65535)
//   CNT_W     : width of each per-button debounce counter
//
// Ports
//   clk1          in   sole clock, rising edge
//   reset         in   synchronous, active-high
//   button[3:0]   in   raw asynchronous buttons, active-low
//   ack[3:0]      in   one-cycle clear pulses for event_flags bits
//   clr_ovf       in   one-cycle clear pulse for overflow
//   level[3:0]    out  debounced pressed state (1 = pressed)
//   press_pulse   out  one-cycle strobe on each debounced press
//   release_pulse out  one-cycle strobe on each debounced release
//   event_flags   out  sticky press flags, cleared by ack
//   event_count   out  running total of presses, wraps modulo 2^16
//   overflow      out  sticky: a press hit a still-set event flag
module button_event_capture #(
  parameter int DB_CYCLES = 20000,
  parameter int CNT_W     = 16
) (
  input  logic        clk1,
  input  logic        reset,
  input  logic [3:0]  button,
  input  logic [3:0]  ack,
  input  logic        clr_ovf,
  output logic [3:0]  level,
  output logic [3:0]  press_pulse,
  output logic [3:0]  release_pulse,
  output logic [3:0]  event_flags,
  output logic [15:0] event_count,
  output logic        overflow
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [3:0]       r_meta_p0;
  logic [3:0]       r_sync_p1;
  logic [CNT_W-1:0] r_cnt_p2 [4];
  logic [3:0]       r_level_p2;
  logic [3:0]       r_press_p3;
  logic [3:0]       r_release_p3;
  logic [3:0]       r_flags_p4;
  logic [15:0]      r_count_p4;
  logic             r_ovf_p4;

  logic [3:0]       w_sync;
  logic [3:0]       w_diff;
  logic [3:0]       w_toggle;
  logic             w_ovf_set;

  function automatic logic [15:0] f_popcount(input logic [3:0] v);
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      s = s + {15'd0, v[k]};
    end
    return s;
  endfunction

  // ---- stage p0/p1: two-flop synchronizer; reset loads "released" ----
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_meta_p0 <= '1;
      r_sync_p1 <= '1;
    end else begin
      r_meta_p0 <= button;
      r_sync_p1 <= r_meta_p0;
    end
  end

  // Buttons are active-low; invert so 1 means pressed from here on.
  assign w_sync = ~r_sync_p1;
  assign w_diff = w_sync ^ r_level_p2;

  always_comb begin
    w_toggle = '0;
    for (int i = 0; i < 4; i++) begin
      w_toggle[i] = w_diff[i] && (r_cnt_p2[i] == CNT_LAST);
    end
  end

  // ---- stage p2: per-button debounce counter and accepted level ----
  // Any cycle where the synchronized input agrees with the level restarts
  // the count, so only an unbroken run of DB_CYCLES disagreeing cycles
  // flips the level.
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_level_p2 <= '0;
      for (int i = 0; i < 4; i++) begin
        r_cnt_p2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!w_diff[i]) begin
          r_cnt_p2[i] <= '0;
        end else if (w_toggle[i]) begin
          r_cnt_p2[i]   <= '0;
          r_level_p2[i] <= ~r_level_p2[i];
        end else begin
          r_cnt_p2[i] <= r_cnt_p2[i] + CNT_W'(1);
        end
      end
    end
  end

  // ---- stage p3: edge strobes, registered on the same edge as the level ----
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_press_p3   <= '0;
      r_release_p3 <= '0;
    end else begin
      r_press_p3   <= w_toggle & ~r_level_p2;
      r_release_p3 <= w_toggle &  r_level_p2;
    end
  end

  // A press landing on a flag the host has not yet acknowledged is lost
  // information; an ack in the same cycle means the host has seen it.
  assign w_ovf_set = |(r_press_p3 & r_flags_p4 & ~ack);

  // ---- stage p4: sticky flags, press counter, overflow ----
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_flags_p4 <= '0;
      r_count_p4 <= '0;
      r_ovf_p4   <= 1'b0;
    end else begin
      r_flags_p4 <= (r_flags_p4 & ~ack) | r_press_p3;
      r_count_p4 <= r_count_p4 + f_popcount(r_press_p3);
      r_ovf_p4   <= w_ovf_set | (r_ovf_p4 & ~clr_ovf);
    end
  end

  assign level         = r_level_p2;
  assign press_pulse   = r_press_p3;
  assign release_pulse = r_release_p3;
  assign event_flags   = r_flags_p4;
  assign event_count   = r_count_p4;
  assign overflow      = r_ovf_p4;

endmodule

// File: doc/button_event_capture.md
BUTTON_EVENT_CAPTURE -- requirements
Module: button_event_capture

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 20000; sets the number of consecutive stable cycles required to accept a level change (legal range 2..65535).
REQ-002 SHALL have parameter CNT_W, default 16; sets the width of each per-button debounce counter.
REQ-003 clk1  input  1  sole clock; every register is clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 button  input  4  raw, asynchronous, active-low push-buttons.
REQ-006 ack  input  4  one-cycle clear pulses for event_flags bits, driven from a host trigger endpoint.
REQ-007 clr_ovf  input  1  one-cycle pulse that clears overflow.
REQ-008 level  output  4  debounced pressed state, active-high (1 = pressed).
REQ-009 press_pulse  output  4  one-cycle strobe on each debounced press.
REQ-010 release_pulse  output  4  one-cycle strobe on each debounced release.
REQ-011 event_flags  output  4  sticky press flags, intended for a host wire-out.
REQ-012 event_count  output  16  running total of presses across all buttons.
REQ-013 overflow  output  1  sticky flag: a press occurred while its event_flags bit was still set.

Function
REQ-014 Each button bit SHALL pass through a 2-flop synchronizer and then be inverted; the result is sync[i] (1 = pressed).
REQ-015 Per button, when sync[i] == level[i], the debounce counter SHALL be cleared to 0.
REQ-016 Per button, when sync[i] != level[i] and the counter < DB_CYCLES-1, the counter SHALL increment.
REQ-017 Per button, when sync[i] != level[i] and the counter == DB_CYCLES-1, level[i] SHALL toggle and the counter SHALL clear on the same edge.
REQ-018 Latency: a clean raw edge held stable SHALL change level exactly 2+DB_CYCLES clk1 edges after it is first sampled.
REQ-019 A glitch shorter than DB_CYCLES synchronized cycles SHALL NOT change level; its counter SHALL restart from 0 on return.
REQ-020 press_pulse[i] SHALL be 1 for exactly the cycle after level[i] goes 0->1; it is registered and coincides with level[i] first reading 1.
REQ-021 release_pulse[i] SHALL be 1 for exactly the cycle after level[i] goes 1->0.
REQ-022 event_flags[i] SHALL be set by press_pulse[i] and cleared by ack[i].
REQ-023 If press_pulse[i] and ack[i] are active in the same cycle, event_flags[i] SHALL be set (set wins).
REQ-024 ack[i] while event_flags[i]=0 SHALL have no effect.
REQ-025 event_count SHALL add popcount(press_pulse) (0..4) each cycle, modulo 2^16; 0xFFFF+1 wraps to 0x0000 with no flag.
REQ-026 overflow SHALL set when press_pulse[i]=1 while event_flags[i]=1 and ack[i]=0 for any i.
REQ-027 overflow SHALL clear on clr_ovf, except that a set condition in the same cycle SHALL win.
REQ-028 The four buttons SHALL be fully independent; simultaneous presses SHALL each produce their own pulse and flag.
REQ-029 Outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-030 While reset=1 at a clk1 edge, the following SHALL be forced to 0: level, press_pulse, release_pulse, event_flags, event_count, overflow and all debounce counters.
REQ-031 While reset=1, synchronizer flops SHALL load 1 (released), so no spurious press follows reset.
REQ-032 A button held pressed through reset SHALL produce exactly one press_pulse, 2+DB_CYCLES cycles after reset deasserts.
REQ-033 Reset asserted mid-debounce SHALL abandon the pending transition; no pulse SHALL be emitted for it.

Verification (DB_CYCLES=4 in all scenarios)
REQ-034 button[0] driven 1->0 and held -> level[0]=1 and press_pulse[0]=1 exactly 6 edges later, single cycle; event_flags=4'b0001; event_count=1.
REQ-035 button[1] low for 3 synchronized cycles, then high -> level, press_pulse and event_count all remain 0.
REQ-036 Two presses of button[2] with no ack between -> overflow=1 on the second press_pulse; then clr_ovf -> overflow=0; ack=4'b0100 -> event_flags[2]=0.
REQ-037 press_pulse[3] and ack[3] in the same cycle -> event_flags[3]=1 and overflow=0; all four buttons pressed together -> event_count advances by 4 in one cycle.
REQ-038 event_count preloaded to 0xFFFE by presses, then two further presses on separate buttons in the same cycle -> event_count=0x0000 with no error flag.
REQ-039 button[0] held low, reset pulsed mid-count then released -> one press_pulse 6 edges after reset deasserts; all outputs read 0 during reset.
